// File: rtl/ifmap_buffer_writer.sv
// Write-side controller for the ping-pong ifmap row buffers: packs a row-major pixel
// stream into POY x BUFW banks, zero-pads each row and hands complete banks to data_router.
module ifmap_buffer_writer #(
  parameter int DW    = 32,
  parameter int POY   = 3,
  parameter int BUFW  = 48,
  parameter int NBANK = 2,
  parameter int CW    = $clog2(BUFW),
  parameter int BLKW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CW:0]      cfg_cols,
  input  logic [BLKW-1:0]  cfg_blocks,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             wr_en,
  output logic [1:0]       wr_bank,
  output logic [1:0]       wr_row,
  output logic [CW-1:0]    wr_col,
  output logic [DW-1:0]    wr_data,
  output logic [NBANK-1:0] bank_full,
  input  logic             blkend,
  output logic [1:0]       rd_bank,
  output logic             busy,
  output logic             done,
  output logic             err_blkend
);

  localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam logic [CW:0]   COLS_MAX = (CW+1)'(BUFW);
  localparam logic [1:0]    ROW_LAST = 2'(POY - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(BUFW - 1);

  logic [1:0]       r_state;
  logic [CW:0]      r_cols_q;
  logic [BLKW-1:0]  r_blocks_left;
  logic [1:0]       r_row;
  logic [CW-1:0]    r_col;
  logic [BW-1:0]    r_wbank;
  logic [BW-1:0]    r_rd_bank;
  logic [BW-1:0]    r_set_bank;
  logic             r_set_pending;
  logic [NBANK-1:0] r_bank_full;
  logic             r_wr_en;
  logic [BW-1:0]    r_wr_bank;
  logic [1:0]       r_wr_row;
  logic [CW-1:0]    r_wr_col;
  logic [DW-1:0]    r_wr_data;
  logic             r_done;
  logic             r_err;

  logic [NBANK-1:0] w_set_vec;
  logic [NBANK-1:0] w_clr_vec;
  logic             w_wbank_full;
  logic             w_active;
  logic             w_in_col;
  logic             w_in_ready;
  logic             w_pad;
  logic             w_step;
  logic             w_blk_last;
  logic             w_clr_hit;
  logic [CW:0]      w_cols_clamped;

  function automatic logic [BW-1:0] next_bank(input logic [BW-1:0] b);
    return (NBANK == 1) ? '0 : b + BW'(1);
  endfunction

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_set_vec = '0;
    if (r_set_pending) w_set_vec[r_set_bank] = 1'b1;
    w_clr_vec = '0;
    if (blkend && r_bank_full[r_rd_bank]) w_clr_vec[r_rd_bank] = 1'b1;
    // A block whose flag is still in flight must already count as full for the writer.
    w_wbank_full   = r_bank_full[r_wbank] || (r_set_pending && (r_set_bank == r_wbank));
    w_active       = (r_state == S_FILL) && !w_wbank_full;
    w_in_col       = {1'b0, r_col} < r_cols_q;
    w_in_ready     = w_active && w_in_col;
    w_pad          = w_active && !w_in_col;
    w_step         = w_pad || (w_in_ready && in_valid);
    w_blk_last     = (r_row == ROW_LAST) && (r_col == COL_LAST);
    w_clr_hit      = w_clr_vec[r_wbank];
    w_cols_clamped = ((cfg_cols == '0) || (cfg_cols > COLS_MAX)) ? COLS_MAX : cfg_cols;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cols_q      <= '0;
      r_blocks_left <= '0;
      r_row         <= '0;
      r_col         <= '0;
      r_wbank       <= '0;
      r_rd_bank     <= '0;
      r_set_bank    <= '0;
      r_set_pending <= 1'b0;
      r_bank_full   <= '0;
      r_wr_en       <= 1'b0;
      r_wr_bank     <= '0;
      r_wr_row      <= '0;
      r_wr_col      <= '0;
      r_wr_data     <= '0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_wr_en       <= w_step;
      r_done        <= (r_state == S_FIN);
      r_set_pending <= w_step && w_blk_last;
      // Set and clear always hit different flags (empty vs full bank), so both apply.
      r_bank_full   <= (r_bank_full | w_set_vec) & ~w_clr_vec;
      if (w_clr_vec != '0) r_rd_bank <= next_bank(r_rd_bank);
      if (blkend && !r_bank_full[r_rd_bank]) r_err <= 1'b1;

      if (w_step) begin
        r_wr_bank  <= r_wbank;
        r_wr_row   <= r_row;
        r_wr_col   <= r_col;
        r_wr_data  <= w_pad ? '0 : in_data;
        r_set_bank <= r_wbank;
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= w_blk_last ? 2'd0 : r_row + 2'd1;
        end else begin
          r_col <= r_col + CW'(1);
        end
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cols_q      <= w_cols_clamped;
            r_blocks_left <= cfg_blocks;
            r_row         <= '0;
            r_col         <= '0;
            r_state       <= (cfg_blocks == '0) ? S_FIN : S_FILL;
          end
        end
        S_FILL: begin
          if (w_step && w_blk_last) begin
            r_wbank       <= next_bank(r_wbank);
            r_blocks_left <= r_blocks_left - BLKW'(1);
            r_state       <= (r_blocks_left == BLKW'(1)) ? S_FIN : S_FILL;
          end else if (w_wbank_full) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!w_wbank_full || w_clr_hit) r_state <= S_FILL;
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = w_in_ready;
  assign wr_en      = r_wr_en;
  assign wr_bank    = 2'(r_wr_bank);
  assign wr_row     = r_wr_row;
  assign wr_col     = r_wr_col;
  assign wr_data    = r_wr_data;
  assign bank_full  = r_bank_full;
  assign rd_bank    = 2'(r_rd_bank);
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign err_blkend = r_err;

endmodule

// File: tb/tb_ifmap_buffer_writer.sv
// Self-checking bench for ifmap_buffer_writer: a queue-based model of the block layout
// (pixels in row-major order, zero pad past cfg_cols) is compared against every write.
module tb_ifmap_buffer_writer;

  localparam int DW    = 32;
  localparam int POY   = 3;
  localparam int BUFW  = 48;
  localparam int NBANK = 2;
  localparam int CW    = $clog2(BUFW);
  localparam int BLKW  = 16;

  logic             clk = 1'b0;
  logic             rst, start, in_valid, in_ready, wr_en, blkend, busy, done, err_blkend;
  logic [CW:0]      cfg_cols;
  logic [BLKW-1:0]  cfg_blocks;
  logic [DW-1:0]    in_data, wr_data;
  logic [1:0]       wr_bank, wr_row, rd_bank;
  logic [CW-1:0]    wr_col;
  logic [NBANK-1:0] bank_full;

  typedef struct {
    int            bank;
    int            row;
    int            col;
    logic [DW-1:0] data;
    bit            last;
    bit            fin;
  } wr_t;

  wr_t           exp_q[$];
  logic [DW-1:0] pix_q[$];
  wr_t           mon_e;
  int            n_cmp = 0;
  int            n_mis = 0;
  int            done_cnt = 0;
  int            m_wbank = 0;
  bit            pend_chk = 1'b0;
  int            pend_bank = 0;
  bit            pend_fin = 1'b0;

  always #5 clk = ~clk;

  ifmap_buffer_writer #(
    .DW(DW), .POY(POY), .BUFW(BUFW), .NBANK(NBANK), .CW(CW), .BLKW(BLKW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_cols(cfg_cols), .cfg_blocks(cfg_blocks),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .bank_full(bank_full), .blkend(blkend), .rd_bank(rd_bank), .busy(busy), .done(done),
    .err_blkend(err_blkend)
  );

  function automatic logic bit_of(input logic [NBANK-1:0] v, input int i);
    logic [NBANK-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  // Write monitor: every write must be the next entry of the model, and a bank's flag
  // must rise exactly one cycle after its last write.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (pend_chk) begin
      pend_chk = 1'b0;
      n_cmp++;
      if (bit_of(bank_full, pend_bank) !== 1'b1 || done !== pend_fin) begin
        n_mis++;
        $display("FAIL blk_full bank=%0d flags=%b done=%b, required flag=1 done=%b",
                 pend_bank, bank_full, done, pend_fin);
      end
    end
    if (wr_en === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_mis++;
        $display("FAIL wr_extra bank=%0d row=%0d col=%0d data=%h, required no write",
                 wr_bank, wr_row, wr_col, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (int'(wr_bank) !== mon_e.bank || int'(wr_row) !== mon_e.row ||
            int'(wr_col) !== mon_e.col || wr_data !== mon_e.data) begin
          n_mis++;
          $display("FAIL wr_beat got b%0d r%0d c%0d %h, required b%0d r%0d c%0d %h",
                   wr_bank, wr_row, wr_col, wr_data, mon_e.bank, mon_e.row, mon_e.col, mon_e.data);
        end
        if (mon_e.last) begin
          n_cmp++;
          if (bit_of(bank_full, mon_e.bank) !== 1'b0) begin
            n_mis++;
            $display("FAIL blk_full_early bank=%0d flags=%b, required flag=0 at last write",
                     mon_e.bank, bank_full);
          end
          pend_chk  = 1'b1;
          pend_bank = mon_e.bank;
          pend_fin  = mon_e.fin;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; blkend = 1'b0;
    in_data = '0; cfg_cols = '0; cfg_blocks = '0;
    @(posedge clk); #1;
    exp_q.delete(); pix_q.delete();
    pend_chk = 1'b0; m_wbank = 0; done_cnt = 0;
    rst = 1'b0;
  endtask

  task automatic build_run(input int cols, input int blocks, input bit seq);
    int eff;
    int k;
    wr_t e;
    eff = (cols == 0 || cols > BUFW) ? BUFW : cols;
    k = 0;
    for (int b = 0; b < blocks; b++)
      for (int r = 0; r < POY; r++)
        for (int c = 0; c < BUFW; c++) begin
          e.bank = (m_wbank + b) % NBANK;
          e.row  = r;
          e.col  = c;
          e.last = (r == POY - 1) && (c == BUFW - 1);
          e.fin  = e.last && (b == blocks - 1);
          if (c < eff) begin
            e.data = seq ? DW'(k) : $urandom;
            k++;
            pix_q.push_back(e.data);
          end else begin
            e.data = '0;
          end
          exp_q.push_back(e);
        end
    m_wbank = (m_wbank + blocks) % NBANK;
  endtask

  task automatic do_start(input int cols, input int blocks);
    cfg_cols = (CW+1)'(cols);
    cfg_blocks = BLKW'(blocks);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offers pixels until n are accepted; each accept must show up as the next-cycle write.
  task automatic feed(input int n, input int gap_pct);
    int cyc;
    int got;
    bit acc;
    logic [DW-1:0] px;
    cyc = 0; got = 0;
    while (got < n && cyc < 5000) begin
      in_valid = ($urandom_range(99) >= gap_pct);
      px = (pix_q.size() > 0) ? pix_q[0] : '0;
      in_data = in_valid ? px : $urandom;
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        px = pix_q.pop_front();
        got++;
        n_cmp++;
        if (wr_en !== 1'b1 || wr_data !== px) begin
          n_mis++;
          $display("FAIL accept_latency wr_en=%b data=%h, required 1 %h", wr_en, wr_data, px);
        end
      end
    end
    in_valid = 1'b0;
    if (got < n) begin
      n_cmp++; n_mis++;
      $display("FAIL feed_timeout accepted=%0d required=%0d", got, n);
    end
  endtask

  task automatic wait_end(input string tag);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_mis++;
      $display("FAIL %s_end pending=%0d busy=%b, required 0 0", tag, exp_q.size(), busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; blkend = 1'b0;
    in_data = '0; cfg_cols = '0; cfg_blocks = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({in_ready, wr_en, wr_bank, wr_row, wr_col, wr_data, bank_full, rd_bank, busy, done,
         err_blkend} !== '0) begin
      n_mis++;
      $display("FAIL reset_outputs ready=%b wr_en=%b flags=%b rd=%0d busy=%b done=%b err=%b, required all 0",
               in_ready, wr_en, bank_full, rd_bank, busy, done, err_blkend);
    end
    rst = 1'b0;
  endtask

  task automatic test_full_row();
    do_reset();
    build_run(48, 1, 1'b1);
    do_start(48, 1);
    feed(144, 0);
    wait_end("full_row");
    n_cmp++;
    if (bank_full !== 2'b01 || rd_bank !== 2'd0 || in_ready !== 1'b0 || done_cnt !== 1) begin
      n_mis++;
      $display("FAIL full_row_state flags=%b rd=%0d ready=%b dones=%0d, required 01 0 0 1",
               bank_full, rd_bank, in_ready, done_cnt);
    end
  endtask

  task automatic test_pad();
    do_reset();
    build_run(40, 1, 1'b0);
    do_start(40, 1);
    feed(120, 0);
    wait_end("pad");
    n_cmp++;
    if (bank_full !== 2'b01 || done_cnt !== 1 || pix_q.size() !== 0) begin
      n_mis++;
      $display("FAIL pad_state flags=%b dones=%0d left=%0d, required 01 1 0",
               bank_full, done_cnt, pix_q.size());
    end
  endtask

  task automatic test_gaps();
    do_reset();
    build_run(48, 1, 1'b1);
    do_start(48, 1);
    feed(144, 50);
    wait_end("gaps");
    n_cmp++;
    if (bank_full !== 2'b01 || done_cnt !== 1) begin
      n_mis++;
      $display("FAIL gaps_state flags=%b dones=%0d, required 01 1", bank_full, done_cnt);
    end
  endtask

  task automatic test_wait();
    int cyc;
    do_reset();
    build_run(48, 3, 1'b0);
    do_start(48, 3);
    feed(288, 0);
    cyc = 0;
    while (exp_q.size() > 144 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (bank_full !== 2'b11 || busy !== 1'b1 || in_ready !== 1'b0 || exp_q.size() !== 144) begin
      n_mis++;
      $display("FAIL wait_state flags=%b busy=%b ready=%b pending=%0d, required 11 1 0 144",
               bank_full, busy, in_ready, exp_q.size());
    end
    do_start(48, 0);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b1 || done_cnt !== 0 || in_ready !== 1'b0) begin
      n_mis++;
      $display("FAIL start_ignored busy=%b dones=%0d ready=%b, required 1 0 0",
               busy, done_cnt, in_ready);
    end
    blkend = 1'b1;
    @(posedge clk); #1;
    blkend = 1'b0;
    n_cmp++;
    if (bank_full !== 2'b10 || rd_bank !== 2'd1 || in_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL wait_release flags=%b rd=%0d ready=%b, required 10 1 1",
               bank_full, rd_bank, in_ready);
    end
    feed(144, 0);
    wait_end("wait");
    n_cmp++;
    if (bank_full !== 2'b11 || done_cnt !== 1 || err_blkend !== 1'b0) begin
      n_mis++;
      $display("FAIL wait_final flags=%b dones=%0d err=%b, required 11 1 0",
               bank_full, done_cnt, err_blkend);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    build_run(48, 2, 1'b0);
    do_start(48, 2);
    feed(288, 0);
    n_cmp++;
    if (bank_full !== 2'b01) begin
      n_mis++;
      $display("FAIL same_cycle_before flags=%b, required 01", bank_full);
    end
    blkend = 1'b1;
    @(posedge clk); #1;
    blkend = 1'b0;
    n_cmp++;
    if (bank_full !== 2'b10 || rd_bank !== 2'd1) begin
      n_mis++;
      $display("FAIL same_cycle_after flags=%b rd=%0d, required 10 1", bank_full, rd_bank);
    end
    wait_end("same_cycle");
    blkend = 1'b1;
    @(posedge clk); #1;
    blkend = 1'b0;
    n_cmp++;
    if (bank_full !== 2'b00 || rd_bank !== 2'd0 || err_blkend !== 1'b0) begin
      n_mis++;
      $display("FAIL drain_idle flags=%b rd=%0d err=%b, required 00 0 0",
               bank_full, rd_bank, err_blkend);
    end
    blkend = 1'b1;
    @(posedge clk); #1;
    blkend = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bank_full !== 2'b00 || rd_bank !== 2'd0 || err_blkend !== 1'b1) begin
      n_mis++;
      $display("FAIL err_blkend flags=%b rd=%0d err=%b, required 00 0 1",
               bank_full, rd_bank, err_blkend);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    build_run(48, 1, 1'b0);
    do_start(48, 1);
    feed(70, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({in_ready, wr_en, wr_bank, wr_row, wr_col, wr_data, bank_full, rd_bank, busy, done,
         err_blkend} !== '0) begin
      n_mis++;
      $display("FAIL reset_mid ready=%b wr_en=%b flags=%b busy=%b done=%b, required all 0",
               in_ready, wr_en, bank_full, busy, done);
    end
    do_reset();
    build_run(48, 1, 1'b1);
    do_start(48, 1);
    feed(144, 0);
    wait_end("reset_mid");
    n_cmp++;
    if (bank_full !== 2'b01 || done_cnt !== 1) begin
      n_mis++;
      $display("FAIL reset_mid_rerun flags=%b dones=%0d, required 01 1", bank_full, done_cnt);
    end
  endtask

  task automatic test_zero_blocks();
    do_reset();
    do_start(10, 0);
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_mis++;
      $display("FAIL zero_fin busy=%b done=%b, required 1 0", busy, done);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b1 || bank_full !== 2'b00) begin
      n_mis++;
      $display("FAIL zero_done busy=%b done=%b flags=%b, required 0 1 00", busy, done, bank_full);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0) begin
      n_mis++;
      $display("FAIL zero_pulse done=%b, required 0", done);
    end
  endtask

  task automatic test_random();
    int cols;
    int blocks;
    int gap;
    int npix;
    for (int i = 0; i < 4; i++) begin
      do_reset();
      cols   = (i == 0) ? 0 : int'($urandom_range(60, 1));
      blocks = int'($urandom_range(2, 1));
      gap    = int'($urandom_range(70, 0));
      build_run(cols, blocks, 1'b0);
      npix = pix_q.size();
      do_start(cols, blocks);
      feed(npix, gap);
      wait_end("random");
      n_cmp++;
      if (bank_full !== NBANK'((1 << blocks) - 1) || done_cnt !== 1) begin
        n_mis++;
        $display("FAIL random_state cols=%0d blocks=%0d flags=%b dones=%0d, required %b 1",
                 cols, blocks, bank_full, done_cnt, NBANK'((1 << blocks) - 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_row();
    test_pad();
    test_gaps();
    test_wait();
    test_same_cycle();
    test_reset_mid();
    test_zero_blocks();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/ifmap_buffer_writer.md
Name: ifmap_buffer_writer

Overview:
- Write-side controller for the ping-pong input feature-map row buffers that data_router reads.
- Accepts a valid/ready pixel stream (row-major, one DW word per beat).
- Packs pixels into NBANK banks of POY rows x BUFW columns, zero-pads unused columns, and marks a bank full when its block is complete.
- Frees a bank when data_router signals blkend, so fill and compute overlap.

Parameters:
DW, 32, pixel word width
POY, 3, rows per block (row buffers per bank)
BUFW, 48, columns per row buffer
NBANK, 2, number of ping-pong banks (power of 2, max 4)
CW, $clog2(BUFW), column address width
BLKW, 16, block-count width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; latches cfg_cols and cfg_blocks; ignored unless IDLE
cfg_cols  in  CW+1  valid pixels per row; 0 or >BUFW is clamped to BUFW
cfg_blocks  in  BLKW  blocks to write; 0 means finish immediately
in_valid  in  1  stream pixel valid
in_ready  out  1  stream pixel accept
in_data  in  DW  stream pixel
wr_en  out  1  buffer write strobe
wr_bank  out  2  write bank index
wr_row  out  2  write row index (0..POY-1)
wr_col  out  CW  write column index
wr_data  out  DW  write data
bank_full  out  NBANK  per-bank block-complete flag, consumed by data_router
blkend  in  1  data_router done with the current read bank (one-cycle pulse)
rd_bank  out  2  bank data_router must read next
busy  out  1  high while not IDLE
done  out  1  one-cycle pulse when the final block is marked full
err_blkend  out  1  sticky: blkend received while bank_full[rd_bank]==0

Behaviour:
- Reset: state IDLE, all outputs 0, wbank=rd_bank=0, row/col counters 0, latched config 0. Reset mid-fill discards the partial block; no bank_full is set.
- States: IDLE, FILL, WAIT, FIN.
  - IDLE: start with cfg_blocks==0 goes to FIN; otherwise goes to FILL with row=col=0.
  - FILL: when bank_full[wbank]==1, go to WAIT and hold counters.
  - WAIT: when bank_full[wbank]==0, return to FILL. If the blkend that frees wbank arrives in WAIT, FILL resumes the next cycle.
  - FIN: pulse done for 1 cycle, then IDLE.
- Column handling in FILL with bank not full:
  - col < cols_q: in_ready=1 (combinational from state/counters only, never from in_valid). The counter advances only on in_valid&in_ready. in_valid low means no write and no advance.
  - col >= cols_q (pad region): in_ready=0. A zero word is written every cycle with no input consumed.
- Write latency: wr_en, wr_bank, wr_row, wr_col and wr_data are registered. They appear exactly 1 cycle after the accept or pad cycle.
- Counters: col wraps BUFW-1 to 0 and increments row. When row==POY-1 and col==BUFW-1, the block is complete:
  - bank_full[wbank] sets 1 cycle after the last wr_en, i.e. 2 cycles after the last accept/pad.
  - wbank increments mod NBANK.
  - blocks_left decrements. Reaching 0 goes to FIN; otherwise stay in FILL (or WAIT if the next bank is full).
- blkend handling:
  - With bank_full[rd_bank]==1: clear that flag next cycle and increment rd_bank mod NBANK.
  - With bank_full[rd_bank]==0: ignored, err_blkend set (cleared only by rst).
- Simultaneous set (writer) and clear (blkend) on the same cycle always target different bank states and are both applied. Set requires the bank empty and clear requires it full, so they cannot collide on one flag.
- start while busy is ignored. blkend is honoured in all states, including IDLE, so the reader can drain after done.
- Each block writes exactly POY*BUFW words. Every word in the pad region is 0.

Test Plan:
1. cfg_cols=48, cfg_blocks=1, in_valid always 1, data=0..143 -> 144 wr_en beats; data k written at row k/48, col k%48, bank 0; bank_full=01 two cycles after the last accept; done pulses; in_ready low afterward.
2. cfg_cols=40, cfg_blocks=1 -> per row 40 accepted words then 8 zero writes with in_ready=0; 120 words consumed, 144 writes total.
3. cfg_blocks=3, blkend never asserted -> banks 0 and 1 fill, bank_full=11, state WAIT, in_ready=0. Pulse blkend -> bank_full=10, rd_bank=1, block 3 writes to bank 0 and done fires.
4. Random in_valid gaps (50%) with cfg_cols=48 -> write addresses and data identical to scenario 1 with gaps only; no write when in_valid=0.
5. blkend at the same cycle bank 1 becomes full (bank 0 full) -> bank_full goes 01 to 10 in one cycle step; no flag lost. blkend with bank_full=00 -> err_blkend=1.
6. rst asserted at word 70 of block 0 -> next cycle all outputs 0 and bank_full=00. A new start rewrites from bank 0, row 0, col 0.
